// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared SNN types, default sizes and width helpers
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ARGMAX,
    ST_HOLD
  } state_t;

  localparam int DEF_N_OUT  = 10;
  localparam int DEF_WINDOW = 64;

  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int idx_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/spike_counter.sv
// rtl/spike_counter.sv - per-neuron spike counter with synchronous clear
module spike_counter #(
  parameter int CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] count
);

  // Width covers the whole window, so no wrap or saturation is possible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && spike) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/output_layer_decoder.sv
// rtl/output_layer_decoder.sv - windowed spike-rate decoder with sequential argmax
module output_layer_decoder
  import snn_pkg::*;
#(
  parameter int N_OUT  = DEF_N_OUT,
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = cnt_width(WINDOW),
  parameter int IDX_W  = idx_width(N_OUT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_spike_valid,
  input  logic [N_OUT-1:0] i_spikes,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_class,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tie
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] ts_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0] best_cnt, best_cnt_nxt;
  logic [IDX_W-1:0] best_idx, best_idx_nxt;
  logic             tie, tie_nxt;
  logic [CNT_W-1:0] cnt [N_OUT];
  logic [CNT_W-1:0] scan_cnt;
  logic             clr, beat, last_beat, last_scan;

  assign clr       = (state == ST_IDLE) && i_start;
  assign beat      = (state == ST_ACCUM) && i_spike_valid;
  assign last_beat = beat && (ts_cnt == CNT_W'(WINDOW - 1));
  assign last_scan = (state == ST_ARGMAX) && (scan_idx == IDX_W'(N_OUT - 1));
  assign scan_cnt  = cnt[scan_idx];

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    spike_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .clr  (clr),
      .en   (beat),
      .spike(i_spikes[k]),
      .count(cnt[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_start) state_nxt = ST_ACCUM;
      ST_ACCUM:  if (last_beat) state_nxt = ST_ARGMAX;
      ST_ARGMAX: if (last_scan) state_nxt = ST_HOLD;
      ST_HOLD:   if (i_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Index 0 seeds the running best; later entries only replace on strictly greater,
  // so the lowest index wins among equals.
  always_comb begin
    best_cnt_nxt = best_cnt;
    best_idx_nxt = best_idx;
    tie_nxt      = tie;
    if (scan_idx == '0) begin
      best_cnt_nxt = scan_cnt;
      best_idx_nxt = '0;
      tie_nxt      = 1'b0;
    end else if (scan_cnt > best_cnt) begin
      best_cnt_nxt = scan_cnt;
      best_idx_nxt = scan_idx;
      tie_nxt      = 1'b0;
    end else if (scan_cnt == best_cnt) begin
      tie_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ts_cnt   <= '0;
      scan_idx <= '0;
      best_cnt <= '0;
      best_idx <= '0;
      tie      <= 1'b0;
      o_class  <= '0;
      o_count  <= '0;
      o_tie    <= 1'b0;
    end else begin
      if (clr) begin
        ts_cnt <= '0;
      end else if (beat) begin
        ts_cnt <= ts_cnt + 1'b1;
      end

      if (last_beat) begin
        scan_idx <= '0;
      end else if (state == ST_ARGMAX) begin
        scan_idx <= scan_idx + 1'b1;
        best_cnt <= best_cnt_nxt;
        best_idx <= best_idx_nxt;
        tie      <= tie_nxt;
      end

      // Result registers persist past HOLD until the next scan completes.
      if (last_scan) begin
        o_class <= best_idx_nxt;
        o_count <= best_cnt_nxt;
        o_tie   <= tie_nxt;
      end
    end
  end

  assign o_busy  = (state == ST_ACCUM) || (state == ST_ARGMAX);
  assign o_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_output_layer_decoder.sv
// tb/tb_output_layer_decoder.sv - scoreboard bench for output_layer_decoder
module tb_output_layer_decoder;

  localparam int N_OUT  = 10;
  localparam int WINDOW = 64;
  localparam int CNT_W  = 7;
  localparam int IDX_W  = 4;

  localparam int PAT_RAND   = 0;
  localparam int PAT_SINGLE = 1;
  localparam int PAT_TIE    = 2;
  localparam int PAT_ZERO   = 3;
  localparam int PAT_SPARSE = 4;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_spike_valid = 1'b0;
  logic [N_OUT-1:0] i_spikes = '0;
  logic             i_ready = 1'b0;
  logic             o_busy, o_valid, o_tie;
  logic [IDX_W-1:0] o_class;
  logic [CNT_W-1:0] o_count;

  typedef struct {
    int cls;
    int cnt;
    int tie;
    int vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_valid = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  output_layer_decoder #(
    .N_OUT (N_OUT),
    .WINDOW(WINDOW),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_spike_valid(i_spike_valid),
    .i_spikes     (i_spikes),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_class      (o_class),
    .o_count      (o_count),
    .o_tie        (o_tie)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops one expectation per result and checks it on every HOLD cycle.
  always @(negedge clk) begin
    if (o_valid) begin
      if (!prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
          have_cur = 1'b0;
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          check("valid_latency", cyc, cur.vcyc);
        end
      end
      if (have_cur) begin
        check("class", int'(o_class), cur.cls);
        check("count", int'(o_count), cur.cnt);
        check("tie", int'(o_tie), cur.tie);
        check("busy_in_hold", int'(o_busy), 0);
      end
    end
    prev_valid = o_valid;
  end

  task automatic do_window(input int pat, input bit gaps, input bit junk, input int hold_n);
    logic [N_OUT-1:0] vec [WINDOW];
    int rate [N_OUT];
    int lim [N_OUT];
    int cnt [N_OUT];
    int best, nbest, b;
    exp_t e;

    for (int k = 0; k < N_OUT; k++) begin
      rate[k] = $urandom_range(0, 99);
      lim[k]  = $urandom_range(0, 19);
    end
    for (int bb = 0; bb < WINDOW; bb++) begin
      vec[bb] = '0;
      for (int k = 0; k < N_OUT; k++) begin
        case (pat)
          PAT_RAND:   vec[bb][k] = ($urandom_range(0, 99) < rate[k]);
          PAT_SINGLE: vec[bb][k] = (k == 3);
          PAT_TIE:    vec[bb][k] = (k == 2) ? (bb < 20) :
                                   (k == 7) ? (bb >= WINDOW - 20) : (bb < lim[k]);
          PAT_SPARSE: vec[bb][k] = ($urandom_range(0, 31) == 0);
          default:    vec[bb][k] = 1'b0;
        endcase
      end
    end

    // Reference: highest total wins, lowest index on equality, tie if the max is shared.
    best = -1;
    e.cls = 0;
    for (int k = 0; k < N_OUT; k++) begin
      cnt[k] = 0;
      for (int bb = 0; bb < WINDOW; bb++) cnt[k] += int'(vec[bb][k]);
      if (cnt[k] > best) begin
        best  = cnt[k];
        e.cls = k;
      end
    end
    nbest = 0;
    for (int k = 0; k < N_OUT; k++) if (cnt[k] == best) nbest++;
    e.cnt = best;
    e.tie = (nbest > 1) ? 1 : 0;

    @(negedge clk);
    i_ready = 1'b0;
    check("valid_drop", int'(o_valid), 0);
    check("idle_busy", int'(o_busy), 0);
    if (junk) begin
      repeat ($urandom_range(1, 3)) begin
        i_spike_valid = 1'b1;
        i_spikes = N_OUT'($urandom);
        @(negedge clk);
      end
    end
    i_start = 1'b1;
    i_spike_valid = junk;
    i_spikes = N_OUT'($urandom);
    @(negedge clk);
    check("busy_after_start", int'(o_busy), 1);
    i_start = 1'b0;

    b = 0;
    while (b < WINDOW) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_spike_valid = 1'b0;
        i_spikes = N_OUT'($urandom);
      end else begin
        i_spike_valid = 1'b1;
        i_spikes = vec[b];
        b++;
        if (b == WINDOW) begin
          e.vcyc = cyc + 1 + N_OUT;
          sb.push_back(e);
        end
      end
      i_start = junk && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end

    for (int i = 0; i < N_OUT + 8 && !o_valid; i++) begin
      i_start = junk && ($urandom_range(0, 1) == 0);
      i_spike_valid = junk && ($urandom_range(0, 1) == 0);
      i_spikes = N_OUT'($urandom);
      @(negedge clk);
    end
    check("valid_arrive", int'(o_valid), 1);
    repeat (hold_n) begin
      i_start = junk && ($urandom_range(0, 1) == 0);
      @(negedge clk);
    end
    check("valid_before_ready", int'(o_valid), 1);
    i_start = 1'b0;
    i_spike_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  task automatic reset_mid_window();
    @(negedge clk);
    i_ready = 1'b0;
    i_start = 1'b1;
    i_spike_valid = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) begin
      i_spike_valid = 1'b1;
      i_spikes = '1;
      @(negedge clk);
    end
    i_spike_valid = 1'b0;
    check("busy_mid_window", int'(o_busy), 1);
    i_rst = 1'b1;
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_class", int'(o_class), 0);
    check("rst_count", int'(o_count), 0);
    check("rst_tie", int'(o_tie), 0);
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("reset_busy", int'(o_busy), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_class", int'(o_class), 0);
    check("reset_count", int'(o_count), 0);
    check("reset_tie", int'(o_tie), 0);
    @(negedge clk);
    i_rst = 1'b0;

    do_window(PAT_SINGLE, 1'b0, 1'b0, 15);
    do_window(PAT_TIE, 1'b0, 1'b0, 0);
    do_window(PAT_ZERO, 1'b0, 1'b1, 2);
    reset_mid_window();
    do_window(PAT_RAND, 1'b1, 1'b1, 3);
    for (int w = 0; w < 6; w++) begin
      do_window(($urandom_range(0, 1) == 0) ? PAT_RAND : PAT_SPARSE,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 4));
    end

    @(negedge clk);
    i_ready = 1'b0;
    check("final_valid_drop", int'(o_valid), 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    check("watchdog", 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
